// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
//   Request/response bundle between the CPU memory stage and mem_access_unit.
//   One request is in flight at a time. A request is accepted when req_valid
//   and req_ready are both high at a rising clock edge. The response is a
//   single-cycle rsp_valid pulse and cannot be back-pressured.
//
//   Signals
//     req_valid     master->slave  request present
//     req_ready     slave->master  unit is idle and can take a request
//     req_we        master->slave  1 store, 0 load
//     req_size      master->slave  00 byte, 01 half, 10 word, 11 illegal
//     req_unsigned  master->slave  loads: 1 zero-extend, 0 sign-extend
//     req_addr      master->slave  byte address
//     req_wdata     master->slave  store data, right-aligned
//     rsp_valid     slave->master  one-cycle response pulse
//     rsp_err       slave->master  request was misaligned or had an illegal size
//     rsp_rdata     slave->master  load result (0 for stores and errors)
// ----------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//   Load/store front end between the CPU memory stage and a word-wide
//   synchronous ram. Accepts one byte/half/word request at a time, reads or
//   writes the ram, and returns sign- or zero-extended load data. Sub-word
//   stores are performed as read-modify-write. Misaligned requests and the
//   illegal size code are answered with rsp_err without touching the ram.
//
//   Parameters
//     WORD_ADDR  1: ram_addr = {2'b00, addr[31:2]} (ram indexed by word)
//                0: ram_addr = {addr[31:2], 2'b00}
//
//   Ports
//     clk             clock, all state on the rising edge
//     rst_n           asynchronous active-low reset
//     bus             request/response interface (slave side)
//     read_ram        ram read strobe, one cycle per access
//     write_ram       ram write strobe, one cycle per access
//     ram_addr        ram address, held for the whole operation
//     ram_write_data  ram write data, zero except while writing
//     ram_out         ram read data, valid the cycle after read_ram
//
//   Latency from the accepting edge: load 3, word store 2, sub-word store 4,
//   error 1 cycle(s).
// ----------------------------------------------------------------------------
module mem_access_unit #(
  parameter bit WORD_ADDR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    bus,
  output logic                read_ram,
  output logic                write_ram,
  output logic [31:0]         ram_addr,
  output logic [31:0]         ram_write_data,
  input  logic [31:0]         ram_out
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    RMW_RD,
    MERGE,
    WR,
    RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        req_bad;

  // Extract the addressed lane from a ram word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic        is_unsigned,
    input logic [1:0]  off
  );
    logic [31:0] lane;
    logic [31:0] res;
    res = word;
    unique case (size)
      SZ_BYTE: begin
        lane = word >> {off, 3'b000};
        res  = is_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        lane = word >> {off[1], 4'b0000};
        res  = is_unsigned ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte or half of the old ram word with store data.
  function automatic logic [31:0] store_merge(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic [1:0]  size,
    input logic [1:0]  off
  );
    logic [31:0] mask;
    logic [31:0] data;
    if (size == SZ_BYTE) begin
      mask = 32'h0000_00ff << {off, 3'b000};
      data = {24'h0, wdata[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_ffff << {off[1], 4'b0000};
      data = {16'h0, wdata[15:0]} << {off[1], 4'b0000};
    end
    return (old_word & ~mask) | data;
  endfunction

  // Illegal size, or an address not aligned to the access size.
  assign req_bad = (bus.req_size == 2'b11)
                 || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                 || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (req_bad) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
            state_d     = RESP;
          end else if (!bus.req_we) begin
            state_d = RD;
          end else if (bus.req_size == SZ_WORD) begin
            state_d = WR;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = load_extract(ram_out, size_q, uns_q, addr_q[1:0]);
        state_d     = RESP;
      end
      RMW_RD:  state_d = MERGE;
      MERGE: begin
        buf_d   = store_merge(ram_out, wdata_q, size_q, addr_q[1:0]);
        state_d = WR;
      end
      WR: begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The response flop is high exactly for the cycle spent in RESP.
    rsp_valid_d = (state_d == RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  // NOTE: the merge buffer is a single register, not a memory array, so it is
  // reset along with everything else; nothing here needs to stay unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Ram strobes decode straight from the state flop, so an asynchronous reset
  // drops them immediately and an interrupted read-modify-write never writes.
  assign read_ram  = (state_q == RD) || (state_q == RMW_RD);
  assign write_ram = (state_q == WR);

  assign ram_addr = (state_q == IDLE) ? 32'h0
                  : (WORD_ADDR ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00});

  assign ram_write_data = (state_q != WR)    ? 32'h0
                        : (size_q == SZ_WORD) ? wdata_q
                        : buf_q;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a behavioural synchronous ram.
//   Stimulus pushes the expected response (error flag, data, cycle) into a
//   queue; an independent monitor pops and compares on every rsp_valid.
//   A second monitor logs ram strobes so each request's ram traffic can be
//   compared with the expected read/write sequence.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  logic        read_ram;
  logic        write_ram;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_out;

  mem_access_unit #(.WORD_ADDR(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .read_ram      (read_ram),
    .write_ram     (write_ram),
    .ram_addr      (ram_addr),
    .ram_write_data(ram_write_data),
    .ram_out       (ram_out)
  );

  // Word-indexed synchronous ram; returns the addressed word every cycle.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (write_ram) mem[ram_addr[7:0]] <= ram_write_data;
    ram_out <= mem[ram_addr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    int          cyc;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;
  op_t ops[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_err",   {31'b0, bus.rsp_err}, {31'b0, mon_e.err});
        check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        check("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Ram strobe monitor.
  always @(negedge clk) begin
    if (rst_n && (read_ram || write_ram)) begin
      ops.push_back('{cyc, read_ram, write_ram, ram_addr, ram_write_data});
      check("rd_wr_exclusive", {31'b0, read_ram & write_ram}, 32'd0);
      if (read_ram) check("wdata_zero_on_read", ram_write_data, 32'd0);
    end
  end

  // Present a request at a negedge, wait (bounded) for acceptance, and
  // optionally push the expected response. Returns at the next negedge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input int lat, input bit push_exp, input bit hold,
                       output int acc);
    int waited;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (push_exp) exp_q.push_back('{exp_err, exp_rdata, cyc + lat});
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // kind: 0 no access, 1 load, 2 word store, 3 read-modify-write store.
  task automatic check_ops(input string nm, input int acc, input int kind,
                           input logic [31:0] waddr, input logic [31:0] wdat);
    int n_exp;
    n_exp = (kind == 0) ? 0 : (kind == 3) ? 2 : 1;
    check({nm, "_nops"}, ops.size(), n_exp);
    if (ops.size() == n_exp && n_exp > 0) begin
      check({nm, "_op0_cyc"},  ops[0].cyc, acc + 1);
      check({nm, "_op0_rdwr"}, {30'b0, ops[0].rd, ops[0].wr}, (kind == 2) ? 32'd1 : 32'd2);
      check({nm, "_op0_addr"}, ops[0].addr, waddr);
      if (kind == 2) check({nm, "_op0_data"}, ops[0].data, wdat);
      if (kind == 3) begin
        check({nm, "_op1_cyc"},  ops[1].cyc, acc + 3);
        check({nm, "_op1_rdwr"}, {30'b0, ops[1].rd, ops[1].wr}, 32'd1);
        check({nm, "_op1_addr"}, ops[1].addr, waddr);
        check({nm, "_op1_data"}, ops[1].data, wdat);
      end
    end
  endtask

  task automatic do_load(input string nm, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    int acc;
    ops.delete();
    issue(1'b0, size, uns, addr, 32'h0, 1'b0, exp, 3, 1'b1, 1'b0, acc);
    wait_done();
    check_ops(nm, acc, 1, {2'b00, addr[31:2]}, 32'h0);
  endtask

  task automatic do_store(input string nm, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_wr);
    int acc;
    ops.delete();
    issue(1'b1, size, 1'b0, addr, wdata, 1'b0, 32'h0, (size == 2'b10) ? 2 : 4,
          1'b1, 1'b0, acc);
    wait_done();
    check_ops(nm, acc, (size == 2'b10) ? 2 : 3, {2'b00, addr[31:2]}, exp_wr);
  endtask

  task automatic do_error(input string nm, input logic we, input logic [1:0] size,
                          input logic [31:0] addr);
    int acc;
    ops.delete();
    issue(we, size, 1'b0, addr, 32'hCAFE_F00D, 1'b1, 32'h0, 1, 1'b1, 1'b0, acc);
    wait_done();
    check_ops(nm, acc, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    int acc2;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_req_ready",      {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid",      {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err",        {31'b0, bus.rsp_err},   32'd0);
    check("rst_rsp_rdata",      bus.rsp_rdata,          32'd0);
    check("rst_read_ram",       {31'b0, read_ram},      32'd0);
    check("rst_write_ram",      {31'b0, write_ram},     32'd0);
    check("rst_ram_addr",       ram_addr,               32'd0);
    check("rst_ram_write_data", ram_write_data,         32'd0);

    // Word store then word load.
    do_store("st_word", 2'b10, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("ld_word",  2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);

    // Sub-word loads with sign/zero extension from 0xDEADBEEF.
    do_load("ld_b_s_103", 2'b00, 1'b0, 32'h103, 32'hFFFF_FFDE);
    do_load("ld_b_u_103", 2'b00, 1'b1, 32'h103, 32'h0000_00DE);
    do_load("ld_b_s_100", 2'b00, 1'b0, 32'h100, 32'hFFFF_FFEF);
    do_load("ld_b_u_101", 2'b00, 1'b1, 32'h101, 32'h0000_00BE);
    do_load("ld_h_s_102", 2'b01, 1'b0, 32'h102, 32'hFFFF_DEAD);
    do_load("ld_h_u_100", 2'b01, 1'b1, 32'h100, 32'h0000_BEEF);

    // Read-modify-write stores.
    do_store("st_b_101", 2'b00, 32'h101, 32'h0000_0055, 32'hDEAD_55EF);
    do_load("ld_after_b", 2'b10, 1'b0, 32'h100, 32'hDEAD_55EF);
    do_store("st_h_102", 2'b01, 32'h102, 32'hABCD_1234, 32'h1234_55EF);
    do_load("ld_after_h", 2'b10, 1'b0, 32'h100, 32'h1234_55EF);
    do_load("ld_h_s_100_pos", 2'b01, 1'b0, 32'h100, 32'h0000_55EF);

    // Rejected requests: no ram traffic, single-cycle error response.
    do_error("err_half_101",  1'b0, 2'b01, 32'h101);
    do_error("err_word_102",  1'b1, 2'b10, 32'h102);
    do_error("err_size_11",   1'b0, 2'b11, 32'h100);
    do_load("ld_after_err", 2'b10, 1'b0, 32'h100, 32'h1234_55EF);

    // Reset during MERGE of a byte store: no write, no response.
    do_store("st_word_200", 2'b10, 32'h200, 32'h1122_3344, 32'h1122_3344);
    ops.delete();
    issue(1'b1, 2'b00, 1'b0, 32'h200, 32'h0000_00AA, 1'b0, 32'h0, 4, 1'b0, 1'b0, acc1);
    @(negedge clk);   // now in MERGE
    rst_n = 1'b0;
    #1;
    check("mrst_write_ram",      {31'b0, write_ram},     32'd0);
    check("mrst_read_ram",       {31'b0, read_ram},      32'd0);
    check("mrst_req_ready",      {31'b0, bus.req_ready}, 32'd1);
    check("mrst_rsp_valid",      {31'b0, bus.rsp_valid}, 32'd0);
    check("mrst_ram_addr",       ram_addr,               32'd0);
    check("mrst_ram_write_data", ram_write_data,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mrst_nops", ops.size(), 32'd1);
    do_load("ld_after_mrst", 2'b10, 1'b0, 32'h200, 32'h1122_3344);

    // Back-to-back loads with req_valid held high.
    ops.delete();
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h1234_55EF, 3, 1'b1, 1'b1, acc1);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, 32'h1122_3344, 3, 1'b1, 1'b0, acc2);
    wait_done();
    check("b2b_second_accept", acc2, acc1 + 4);
    check("b2b_nops", ops.size(), 32'd2);

    repeat (2) @(negedge clk);
    check("end_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
